// File: rtl/riscv_bus_pkg.sv
// Shared types and constants for the instruction/data memory arbiter.
package riscv_bus_pkg;

  localparam int unsigned AddrW = 30;

  typedef enum logic [1:0] {
    IDLE,
    GNT_I,
    GNT_D
  } bus_state_e;

endpackage

// File: rtl/riscv_bus_timeout.sv
// Wait counter for a granted memory access; flags the last allowed cycle without ack.
module riscv_bus_timeout #(
  parameter int unsigned TIMEOUT = 255
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic clr,
  input  logic en,
  output logic expired
);

  localparam int unsigned CntW    = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam int unsigned LastVal = (TIMEOUT > 0) ? TIMEOUT - 1 : 0;
  localparam logic [CntW-1:0] Last = CntW'(LastVal);

  logic [CntW-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (en) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  // TIMEOUT of 0 disables expiry entirely.
  assign expired = (TIMEOUT != 0) && en && (cnt_q == Last);

endmodule

// File: rtl/riscv_mem_arbiter.sv
// Arbitrates fetch and data ports onto one registered memory port with
// round-robin on conflict, back-to-back hand-over and an ack timeout.
module riscv_mem_arbiter
  import riscv_bus_pkg::*;
#(
  parameter int unsigned TIMEOUT = 255
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             ibus_req_i,
  input  logic [AddrW-1:0] ibus_addr_i,
  output logic             ibus_ack_o,
  output logic             ibus_err_o,
  output logic [31:0]      ibus_rdata_o,
  input  logic             dbus_req_i,
  input  logic             dbus_we_i,
  input  logic [AddrW-1:0] dbus_addr_i,
  input  logic [31:0]      dbus_wdata_i,
  output logic             dbus_ack_o,
  output logic             dbus_err_o,
  output logic [31:0]      dbus_rdata_o,
  output logic             mem_req_o,
  output logic             mem_we_o,
  output logic [AddrW-1:0] mem_addr_o,
  output logic [31:0]      mem_wdata_o,
  input  logic [31:0]      mem_rdata_i,
  input  logic             mem_ack_i
);

  bus_state_e       state_q, state_d;
  logic             last_i_q, last_i_d;
  logic             req_q, req_d;
  logic             we_q, we_d;
  logic [AddrW-1:0] addr_q, addr_d;
  logic [31:0]      wdata_q, wdata_d;

  logic granted, expired, done;
  logic grant_i, grant_d;

  assign granted = (state_q != IDLE);
  assign done    = granted && (mem_ack_i || expired);

  riscv_bus_timeout #(
    .TIMEOUT(TIMEOUT)
  ) u_timeout (
    .clk_i  (clk_i),
    .rst_ni (rst_ni),
    .clr    (!granted || done),
    .en     (granted && !mem_ack_i),
    .expired(expired)
  );

  always_comb begin
    state_d  = state_q;
    last_i_d = last_i_q;
    req_d    = req_q;
    we_d     = we_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    grant_i  = 1'b0;
    grant_d  = 1'b0;

    // On completion only the other requester is considered; the served one is masked.
    case (state_q)
      IDLE: begin
        if (ibus_req_i && dbus_req_i) begin
          grant_d = last_i_q;
          grant_i = !last_i_q;
        end else begin
          grant_d = dbus_req_i;
          grant_i = ibus_req_i;
        end
      end
      GNT_I:   grant_d = done && dbus_req_i;
      GNT_D:   grant_i = done && ibus_req_i;
      default: ;
    endcase

    if (grant_d) begin
      state_d  = GNT_D;
      last_i_d = 1'b0;
      req_d    = 1'b1;
      we_d     = dbus_we_i;
      addr_d   = dbus_addr_i;
      wdata_d  = dbus_wdata_i;
    end else if (grant_i) begin
      state_d  = GNT_I;
      last_i_d = 1'b1;
      req_d    = 1'b1;
      we_d     = 1'b0;
      addr_d   = ibus_addr_i;
      wdata_d  = '0;
    end else if (done) begin
      state_d = IDLE;
      req_d   = 1'b0;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q  <= IDLE;
      last_i_q <= 1'b1;
      req_q    <= 1'b0;
      we_q     <= 1'b0;
      addr_q   <= '0;
      wdata_q  <= '0;
    end else begin
      state_q  <= state_d;
      last_i_q <= last_i_d;
      req_q    <= req_d;
      we_q     <= we_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
    end
  end

  assign mem_req_o   = req_q;
  assign mem_we_o    = we_q;
  assign mem_addr_o  = addr_q;
  assign mem_wdata_o = wdata_q;

  assign ibus_ack_o   = (state_q == GNT_I) && mem_ack_i;
  assign dbus_ack_o   = (state_q == GNT_D) && mem_ack_i;
  assign ibus_err_o   = (state_q == GNT_I) && expired;
  assign dbus_err_o   = (state_q == GNT_D) && expired;
  assign ibus_rdata_o = ibus_ack_o ? mem_rdata_i : '0;
  assign dbus_rdata_o = dbus_ack_o ? mem_rdata_i : '0;

endmodule

// File: doc/riscv_mem_arbiter.md
RISCV_MEM_ARBITER -- requirements
Module: riscv_mem_arbiter

Interface
REQ-001 The block SHALL have one clock and one reset: clock clk_i; reset rst_ni is asynchronous and active-low.
REQ-002 Parameter TIMEOUT, default 255, SHALL give the maximum wait in cycles for mem_ack_i; 0 disables the timeout.
REQ-003 Ports SHALL be, one per line (name, direction, width, meaning):
- clk_i  in  1  clock, rising edge
- rst_ni  in  1  asynchronous active-low reset
- ibus_req_i  in  1  fetch request; held with address until ack/err
- ibus_addr_i  in  30  fetch word address [31:2]
- ibus_ack_o  out  1  fetch completed; one-cycle pulse
- ibus_err_o  out  1  fetch timed out; one-cycle pulse
- ibus_rdata_o  out  32  fetch read data; valid with ibus_ack_o
- dbus_req_i  in  1  data request; held stable until ack/err
- dbus_we_i  in  1  1 = store, 0 = load
- dbus_addr_i  in  30  data word address [31:2]
- dbus_wdata_i  in  32  store data
- dbus_ack_o  out  1  data access completed; one-cycle pulse
- dbus_err_o  out  1  data access timed out; one-cycle pulse
- dbus_rdata_o  out  32  load data; valid with dbus_ack_o
- mem_req_o  out  1  memory request, registered
- mem_we_o  out  1  memory write enable, registered
- mem_addr_o  out  30  memory word address, registered
- mem_wdata_o  out  32  memory write data, registered
- mem_rdata_i  in  32  memory read data; valid with mem_ack_i
- mem_ack_i  in  1  memory completion; one-cycle pulse

Function
REQ-004 FSM states SHALL be IDLE, GNT_I and GNT_D.
REQ-005 IDLE -> GNT_I or GNT_D SHALL occur on the edge where a request is sampled; mem_req_o, mem_addr_o, mem_we_o and mem_wdata_o are loaded from the granted requester on that edge (one-cycle request latency).
REQ-006 In GNT_I, mem_we_o SHALL be 0 and mem_wdata_o SHALL be 0.
REQ-007 ack_o, err_o and rdata_o SHALL be combinational from state and mem_ack_i: for example, dbus_ack_o = (state==GNT_D) & mem_ack_i.
REQ-008 rdata_o of the non-granted requester SHALL read 0.
REQ-009 When both requests are sampled in IDLE, the grant SHALL go to the requester not served last; flag last_i holds this and resets to 1, so dbus wins the first conflict.
REQ-010 On the mem_ack_i edge, the served requester's req SHALL be masked for that cycle.
REQ-011 If the other requester is pending at that edge, the FSM SHALL go directly to its grant state and reload the mem_* fields (back-to-back, no idle cycle); otherwise it goes to IDLE with mem_req_o = 0.
REQ-012 A wait counter SHALL clear on grant entry and increment each grant cycle without mem_ack_i.
REQ-013 When the counter equals TIMEOUT-1 without ack, the granted err_o SHALL pulse that cycle, mem_req_o SHALL drop on the next edge, and the FSM SHALL follow the REQ-011 transitions.
REQ-014 mem_ack_i and timeout in the same cycle SHALL resolve as ack; err_o stays 0.
REQ-015 mem_ack_i sampled in IDLE SHALL be ignored, with no ack_o pulse.
REQ-016 Request inputs SHALL NOT be re-sampled during a grant; address changes mid-grant have no effect.
REQ-017 Counter width SHALL be $clog2(TIMEOUT+1), minimum 1.

Reset
REQ-018 Assertion of rst_ni SHALL immediately force: state IDLE; mem_req_o, mem_we_o, mem_addr_o and mem_wdata_o to 0; counter 0; last_i 1.
REQ-019 During reset, all ack, err and rdata outputs SHALL be 0.
REQ-020 Reset mid-transaction SHALL abandon it with no ack or err pulse.
REQ-021 Reset deassertion SHALL take effect at the next rising edge.

Structure
REQ-022 Package riscv_bus_pkg SHALL hold the state enum (IDLE, GNT_I, GNT_D) and the address width constant (30).
REQ-023 The wait counter SHALL be sub-module riscv_bus_timeout (inputs clr, en; output expired; parameter TIMEOUT).

Verification
REQ-024 The bench SHALL cover the following directed scenarios:
- Single load: dbus_req_i=1, we=0, addr=0x100; ack 2 cycles later with rdata 0xDEADBEEF -> mem_req_o high 1 cycle after req; dbus_ack_o pulses with rdata 0xDEADBEEF.
- Conflict: both req in the same cycle after reset -> dbus granted first; on its ack, ibus granted on the next edge with no idle cycle; mem_addr_o = ibus_addr_i.
- Fairness: both req held continuously, 4 acks -> grants alternate D, I, D, I.
- Timeout with TIMEOUT=4: ibus req, no ack -> ibus_err_o pulses in the 4th grant cycle; mem_req_o low on the next cycle; FSM IDLE.
- Ack plus timeout in the same cycle -> ack_o=1 and err_o=0.
- Store with reset mid-grant: dbus we=1, wdata 0x12345678; rst_ni low in the second grant cycle -> mem_we_o and mem_req_o drop to 0 immediately with no ack or err; after release, a new ibus req is granted normally.
